// File: rtl/bcd_counter2_if.sv
// Purpose: bundles the control inputs and digit/pulse outputs of bcd_counter2.
// Latency: none, wires only.
// Backpressure: none; the counter has no flow control.
// Signals: En, Up, Load, LoadVal[7:0] (to counter); BCD1, BCD0, Tick, Carry (from counter).
interface bcd_counter2_if;
    logic       En;
    logic       Up;
    logic       Load;
    logic [7:0] LoadVal;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
    logic       Tick;
    logic       Carry;

    // Master drives the controls and observes the digits.
    modport master (
        output En, Up, Load, LoadVal,
        input  BCD1, BCD0, Tick, Carry
    );

    // Slave is the counter itself.
    modport slave (
        input  En, Up, Load, LoadVal,
        output BCD1, BCD0, Tick, Carry
    );
endinterface

// File: rtl/bcd_counter2.sv
// Purpose: two-digit BCD up/down counter (00-99) stepping once every PRESCALE enabled clocks.
// Latency: 1 clock from Load or a prescaler step to the digits/Tick/Carry; all outputs registered.
// Backpressure: none; En=0 freezes the prescaler and the digits with no loss of partial period.
// Ports: Clock, Reset (sync, active-high); bus.En/Up/Load/LoadVal in; bus.BCD1/BCD0/Tick/Carry out.
// Option: define BCD_COUNTER2_WRAP_EN to wrap 99->00 / 00->99; otherwise the count saturates.
module bcd_counter2 #(
    parameter int PRESCALE = 50000000,
    parameter int PW       = 26
) (
    input logic          Clock,
    input logic          Reset,
    bcd_counter2_if.slave bus
);

    localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pc;
    logic          expire;
    logic [3:0]    nxt1;
    logic [3:0]    nxt0;
    logic          term;

    assign expire = (pc == PC_LAST);

    // Out-of-range load nibbles are forced to 9 so the digits stay decimal.
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Digit values a step would produce, plus whether this step is at a limit.
    always_comb begin
        nxt1 = bus.BCD1;
        nxt0 = bus.BCD0;
        term = 1'b0;
        if (bus.Up) begin
            if (bus.BCD0 < 4'd9) begin
                nxt0 = bus.BCD0 + 4'd1;
            end else if (bus.BCD1 < 4'd9) begin
                nxt0 = 4'd0;
                nxt1 = bus.BCD1 + 4'd1;
            end else begin
                term = 1'b1;
`ifdef BCD_COUNTER2_WRAP_EN
                nxt1 = 4'd0;
                nxt0 = 4'd0;
`endif
            end
        end else begin
            if (bus.BCD0 > 4'd0) begin
                nxt0 = bus.BCD0 - 4'd1;
            end else if (bus.BCD1 > 4'd0) begin
                nxt0 = 4'd9;
                nxt1 = bus.BCD1 - 4'd1;
            end else begin
                term = 1'b1;
`ifdef BCD_COUNTER2_WRAP_EN
                nxt1 = 4'd9;
                nxt0 = 4'd9;
`endif
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc        <= '0;
            bus.BCD1  <= 4'd0;
            bus.BCD0  <= 4'd0;
            bus.Tick  <= 1'b0;
            bus.Carry <= 1'b0;
        end else if (bus.Load) begin
            // Load beats a coincident expiry: no step, period restarts.
            pc        <= '0;
            bus.BCD1  <= clamp9(bus.LoadVal[7:4]);
            bus.BCD0  <= clamp9(bus.LoadVal[3:0]);
            bus.Tick  <= 1'b0;
            bus.Carry <= 1'b0;
        end else if (bus.En && expire) begin
            pc        <= '0;
            bus.BCD1  <= nxt1;
            bus.BCD0  <= nxt0;
            bus.Tick  <= 1'b1;
            bus.Carry <= term;
        end else begin
            // pc only advances while enabled; pulses last a single cycle.
            if (bus.En) begin
                pc <= pc + PW'(1);
            end
            bus.Tick  <= 1'b0;
            bus.Carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter2.sv
// Purpose: directed self-checking bench for bcd_counter2 at PRESCALE 4, 2 and 1.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_bcd_counter2;

    logic Clock;
    logic rst4, rst2, rst1;
    int   errors;
    int   checks;

    bcd_counter2_if if4 ();
    bcd_counter2_if if2 ();
    bcd_counter2_if if1 ();

    bcd_counter2 #(.PRESCALE(4), .PW(3)) dut4 (.Clock(Clock), .Reset(rst4), .bus(if4));
    bcd_counter2 #(.PRESCALE(2), .PW(2)) dut2 (.Clock(Clock), .Reset(rst2), .bus(if2));
    bcd_counter2 #(.PRESCALE(1), .PW(1)) dut1 (.Clock(Clock), .Reset(rst1), .bus(if1));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // {tens, units, Tick, Carry} packed for compact comparisons
    function automatic logic [15:0] st4();
        return {4'h0, if4.BCD1, if4.BCD0, 2'b00, if4.Tick, if4.Carry};
    endfunction
    function automatic logic [15:0] st2();
        return {4'h0, if2.BCD1, if2.BCD0, 2'b00, if2.Tick, if2.Carry};
    endfunction
    function automatic logic [15:0] st1();
        return {4'h0, if1.BCD1, if1.BCD0, 2'b00, if1.Tick, if1.Carry};
    endfunction

    function automatic logic [15:0] exp_st(input logic [7:0] d, input logic t, input logic c);
        return {4'h0, d, 2'b00, t, c};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst4 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
        if4.En = 1'b0; if4.Up = 1'b1; if4.Load = 1'b0; if4.LoadVal = 8'h00;
        if2.En = 1'b0; if2.Up = 1'b1; if2.Load = 1'b0; if2.LoadVal = 8'h00;
        if1.En = 1'b0; if1.Up = 1'b1; if1.Load = 1'b0; if1.LoadVal = 8'h00;
        edges(2);
        chk("reset4", st4(), exp_st(8'h00, 1'b0, 1'b0));
        chk("reset2", st2(), exp_st(8'h00, 1'b0, 1'b0));
        rst4 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;

        // ---- PRESCALE=4 count up ----
        if4.En = 1'b1;
        edges(3);
        chk("up_before4", st4(), exp_st(8'h00, 1'b0, 1'b0));
        edges(1);
        chk("up_first_step", st4(), exp_st(8'h01, 1'b1, 1'b0));
        edges(1);
        chk("tick_one_cycle", st4(), exp_st(8'h01, 1'b0, 1'b0));
        edges(31);
        chk("up_09", st4(), exp_st(8'h09, 1'b1, 1'b0));
        edges(4);
        chk("up_10_at40", st4(), exp_st(8'h10, 1'b1, 1'b0));

        // ---- enable freeze with pc=2 ----
        edges(2);
        if4.En = 1'b0;
        edges(7);
        chk("freeze_hold", st4(), exp_st(8'h10, 1'b0, 1'b0));
        if4.En = 1'b1;
        edges(1);
        chk("freeze_resume1", st4(), exp_st(8'h10, 1'b0, 1'b0));
        edges(1);
        chk("freeze_resume2", st4(), exp_st(8'h11, 1'b1, 1'b0));

        // ---- down from 11 through 10 to 09 ----
        if4.Up = 1'b0;
        edges(4);
        chk("down_10", st4(), exp_st(8'h10, 1'b1, 1'b0));
        edges(4);
        chk("down_09", st4(), exp_st(8'h09, 1'b1, 1'b0));

        // ---- load clamp coinciding with expiry (pc=3) ----
        edges(3);
        if4.Load = 1'b1; if4.LoadVal = 8'hFC;
        edges(1);
        chk("load_clamp_prio", st4(), exp_st(8'h99, 1'b0, 1'b0));
        if4.Load = 1'b0;
        edges(3);
        chk("after_load_wait", st4(), exp_st(8'h99, 1'b0, 1'b0));
        edges(1);
        chk("after_load_step", st4(), exp_st(8'h98, 1'b1, 1'b0));

        // ---- load held three cycles, counting resumes after last ----
        if4.Up = 1'b1;
        if4.Load = 1'b1; if4.LoadVal = 8'h42;
        edges(3);
        chk("load_held", st4(), exp_st(8'h42, 1'b0, 1'b0));
        if4.Load = 1'b0;
        edges(3);
        chk("load_held_wait", st4(), exp_st(8'h42, 1'b0, 1'b0));
        edges(1);
        chk("load_held_step", st4(), exp_st(8'h43, 1'b1, 1'b0));

        // ---- reset on a step cycle at 57 ----
        if4.Load = 1'b1; if4.LoadVal = 8'h57;
        edges(1);
        if4.Load = 1'b0;
        edges(3);
        rst4 = 1'b1;
        edges(1);
        chk("reset_midstep", st4(), exp_st(8'h00, 1'b0, 1'b0));
        rst4 = 1'b0;
        edges(3);
        chk("reset_pc_wait", st4(), exp_st(8'h00, 1'b0, 1'b0));
        edges(1);
        chk("reset_pc_step", st4(), exp_st(8'h01, 1'b1, 1'b0));

        // ---- reset and load together ----
        rst4 = 1'b1; if4.Load = 1'b1; if4.LoadVal = 8'h77;
        edges(1);
        chk("reset_beats_load", st4(), exp_st(8'h00, 1'b0, 1'b0));
        rst4 = 1'b0; if4.Load = 1'b0;

        // ---- PRESCALE=2 terminal up ----
        if2.En = 1'b1; if2.Up = 1'b1;
        if2.Load = 1'b1; if2.LoadVal = 8'h98;
        edges(1);
        chk("p2_load98", st2(), exp_st(8'h98, 1'b0, 1'b0));
        if2.Load = 1'b0;
        edges(2);
        chk("p2_up99", st2(), exp_st(8'h99, 1'b1, 1'b0));
        edges(2);
`ifdef BCD_COUNTER2_WRAP_EN
        chk("p2_up_term", st2(), exp_st(8'h00, 1'b1, 1'b1));
`else
        chk("p2_up_term", st2(), exp_st(8'h99, 1'b1, 1'b1));
`endif
        edges(1);
`ifdef BCD_COUNTER2_WRAP_EN
        chk("p2_up_term_after", st2(), exp_st(8'h00, 1'b0, 1'b0));
`else
        chk("p2_up_term_after", st2(), exp_st(8'h99, 1'b0, 1'b0));
`endif
        edges(1);
`ifdef BCD_COUNTER2_WRAP_EN
        chk("p2_up_next", st2(), exp_st(8'h01, 1'b1, 1'b0));
`else
        chk("p2_up_next", st2(), exp_st(8'h99, 1'b1, 1'b1));
`endif

        // ---- PRESCALE=2 terminal down ----
        if2.Up = 1'b0;
        if2.Load = 1'b1; if2.LoadVal = 8'h01;
        edges(1);
        if2.Load = 1'b0;
        chk("p2_load01", st2(), exp_st(8'h01, 1'b0, 1'b0));
        edges(2);
        chk("p2_down00", st2(), exp_st(8'h00, 1'b1, 1'b0));
        edges(2);
`ifdef BCD_COUNTER2_WRAP_EN
        chk("p2_down_term", st2(), exp_st(8'h99, 1'b1, 1'b1));
`else
        chk("p2_down_term", st2(), exp_st(8'h00, 1'b1, 1'b1));
`endif

        // ---- clamp of high tens nibble only ----
        if2.Load = 1'b1; if2.LoadVal = 8'hA3;
        edges(1);
        if2.Load = 1'b0;
        chk("p2_clampA3", st2(), exp_st(8'h93, 1'b0, 1'b0));

        // ---- PRESCALE=1: step every enabled clock ----
        if1.En = 1'b1;
        edges(1);
        chk("p1_step1", st1(), exp_st(8'h01, 1'b1, 1'b0));
        edges(1);
        chk("p1_step2", st1(), exp_st(8'h02, 1'b1, 1'b0));
        edges(1);
        chk("p1_step3", st1(), exp_st(8'h03, 1'b1, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
